// File: rtl/msg_pkg.sv
// -----------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the host-link message framing, used by the transmit
// framer (msg_uart_tx) and the receive-side parser.
//   MSG_SYNC_BYTE     : frame sync byte (0x7E)
//   MSG_CLKS_PER_BIT  : default UART bit period in CLK cycles (57600 baud @ 100 MHz)
//   msg_state_t       : frame FSM state encoding
// Build option: MSG_TX_CHECKSUM_EN adds the ST_CSUM state.
// -----------------------------------------------------------------------------
package msg_pkg;

   localparam logic [7:0] MSG_SYNC_BYTE    = 8'h7E;
   localparam int         MSG_CLKS_PER_BIT = 1736;

   typedef enum logic [2:0] {
      ST_COLLECT = 3'd0,
      ST_SYNC    = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
`ifdef MSG_TX_CHECKSUM_EN
      ST_CSUM    = 3'd4,
`endif
      ST_DONE    = 3'd5
   } msg_state_t;

endpackage

// File: rtl/msg_uart_tx_if.sv
// -----------------------------------------------------------------------------
// msg_uart_tx_if
// Valid/ready byte stream carrying a frame payload into msg_uart_tx.
//   in_data  : payload byte
//   in_valid : in_data is valid
//   in_last  : final payload byte of the frame
//   in_ready : sink accepts a byte this cycle
// Modports: master (payload source), slave (msg_uart_tx).
// -----------------------------------------------------------------------------
interface msg_uart_tx_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;

   modport master (output in_data, output in_valid, output in_last, input  in_ready);
   modport slave  (input  in_data, input  in_valid, input  in_last, output in_ready);
endinterface

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser, LSB first: start bit, 8 data bits, stop bit, each held
// CLKS_PER_BIT cycles.
//   CLK, reset : clock, synchronous active-high reset
//   tx_byte    : byte to send, captured when start is honoured
//   start      : load tx_byte; honoured when idle or in the last stop-bit cycle
//   tx         : serial line, idle high
//   byte_done  : high during the final cycle of the stop bit
// Starting in the byte_done cycle gives back-to-back bytes with no idle gap.
// -----------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = msg_pkg::MSG_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] tx_byte,
   input  logic       start,
   output logic       tx,
   output logic       byte_done
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_idx;   // 0 start, 1..8 data, 9 stop
   logic [8:0]       shreg;     // remaining data bits with the stop bit on top
   logic             load;
   logic             bit_end;

   assign bit_end   = active && (cnt == CNT_LAST);
   assign byte_done = bit_end && (bit_idx == 4'd9);
   assign load      = start && (!active || byte_done);

   always_ff @(posedge CLK) begin
      if (reset) begin
         active  <= 1'b0;
         tx      <= 1'b1;
         cnt     <= '0;
         bit_idx <= '0;
      end else if (load) begin
         active  <= 1'b1;
         tx      <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
      end else if (active) begin
         if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 4'd9) begin
               active <= 1'b0;
               tx     <= 1'b1;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               tx      <= shreg[0];
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (load)
         shreg <= {1'b1, tx_byte};
      else if (bit_end && (bit_idx != 4'd9))
         shreg <= {1'b0, shreg[8:1]};
   end

endmodule

// File: rtl/msg_uart_tx.sv
// -----------------------------------------------------------------------------
// msg_uart_tx
// Response-path framer: buffers a payload from a valid/ready stream, then sends
// 0x7E, length, payload and (optionally) an XOR checksum as one 8N1 frame.
//   CLK, reset  : clock, synchronous active-high reset
//   in_if       : payload stream (slave side of msg_uart_tx_if)
//   ct_UartTx   : serial line, idle high
//   busy        : frame being transmitted
//   frame_done  : one-cycle pulse after the final stop bit
// Build option: MSG_TX_CHECKSUM_EN appends the checksum byte; LEN = N+1.
// -----------------------------------------------------------------------------
module msg_uart_tx
   import msg_pkg::*;
#(
   parameter int CLKS_PER_BIT = MSG_CLKS_PER_BIT,
   parameter int MAX_PAYLOAD  = 8
) (
   input  logic           CLK,
   input  logic           reset,
   msg_uart_tx_if.slave   in_if,
   output logic           ct_UartTx,
   output logic           busy,
   output logic           frame_done
);

   localparam int               CNT_W    = $clog2(MAX_PAYLOAD + 1);
   localparam int               IDX_W    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PAYLOAD - 1);
`ifdef MSG_TX_CHECKSUM_EN
   localparam logic [7:0]       LEN_ADD  = 8'd1;
`else
   localparam logic [7:0]       LEN_ADD  = 8'd0;
`endif

   msg_state_t       state_q, state_d;
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       pay_mem [MAX_PAYLOAD];
`ifdef MSG_TX_CHECKSUM_EN
   logic [7:0]       csum_q;
`endif
   logic             accept;
   logic             close;
   logic             last_idx;
   logic             start;
   logic [7:0]       tx_byte;
   logic             byte_done;

   assign accept   = (state_q == ST_COLLECT) && in_if.in_valid;
   assign close    = accept && (in_if.in_last || (count_q == CNT_LAST));
   assign last_idx = (CNT_W'(idx_q) == (count_q - 1'b1));

   assign in_if.in_ready = (state_q == ST_COLLECT);
   assign busy           = (state_q != ST_COLLECT) && (state_q != ST_DONE);
   assign frame_done     = (state_q == ST_DONE);

   // Each state launches the next byte in the byte_done cycle of the current
   // one; the sync byte launches on the closing acceptance itself.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      start   = 1'b0;
      tx_byte = MSG_SYNC_BYTE;
      case (state_q)
         ST_COLLECT: begin
            if (close) begin
               state_d = ST_SYNC;
               start   = 1'b1;
            end
         end
         ST_SYNC: begin
            if (byte_done) begin
               state_d = ST_LEN;
               start   = 1'b1;
               tx_byte = 8'(count_q) + LEN_ADD;
            end
         end
         ST_LEN: begin
            if (byte_done) begin
               state_d = ST_PAYLOAD;
               idx_d   = '0;
               start   = 1'b1;
               tx_byte = pay_mem[0];
            end
         end
         ST_PAYLOAD: begin
            if (byte_done) begin
               if (last_idx) begin
`ifdef MSG_TX_CHECKSUM_EN
                  state_d = ST_CSUM;
                  start   = 1'b1;
                  tx_byte = csum_q;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  start   = 1'b1;
                  tx_byte = pay_mem[idx_d];
               end
            end
         end
`ifdef MSG_TX_CHECKSUM_EN
         ST_CSUM: begin
            if (byte_done)
               state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_COLLECT;
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= ST_COLLECT;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept)
            count_q <= count_q + 1'b1;
         else if (state_q == ST_DONE)
            count_q <= '0;
      end
   end

   always_ff @(posedge CLK) begin
      idx_q <= idx_d;
      if (accept && !reset) begin
         pay_mem[count_q[IDX_W-1:0]] <= in_if.in_data;
`ifdef MSG_TX_CHECKSUM_EN
         csum_q <= (count_q == '0) ? in_if.in_data : (csum_q ^ in_if.in_data);
`endif
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .CLK       (CLK),
      .reset     (reset),
      .tx_byte   (tx_byte),
      .start     (start),
      .tx        (ct_UartTx),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_msg_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_msg_uart_tx
// Directed bench for msg_uart_tx with CLKS_PER_BIT=16, MAX_PAYLOAD=8.
// Expected line bytes are queued as each frame is driven; a line decoder pops
// and compares them. Honours MSG_TX_CHECKSUM_EN for the expected frame layout.
// -----------------------------------------------------------------------------
module tb_msg_uart_tx;
   import msg_pkg::*;

   localparam int CPB  = 16;
   localparam int MAXP = 8;
`ifdef MSG_TX_CHECKSUM_EN
   localparam int C = 1;
`else
   localparam int C = 0;
`endif

   logic CLK = 1'b0;
   logic reset;
   logic ct_UartTx, busy, frame_done;
   logic mon_en;

   msg_uart_tx_if bus ();

   msg_uart_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(MAXP)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .in_if      (bus.slave),
      .ct_UartTx  (ct_UartTx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 CLK = ~CLK;

   int         passed = 0;
   int         total  = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected line bytes for one frame.
   task automatic push_frame(input logic [7:0] pl[$]);
      logic [7:0] x;
      x = 8'h00;
      exp_q.push_back(8'h7E);
      exp_q.push_back(8'(pl.size() + C));
      foreach (pl[i]) begin
         exp_q.push_back(pl[i]);
         x = x ^ pl[i];
      end
      if (C == 1) exp_q.push_back(x);
   endtask

   // Drive bytes one per cycle; inputs are left asserted after the last edge.
   task automatic send(input logic [7:0] pl[$], input bit use_last);
      for (int i = 0; i < pl.size(); i++) begin
         @(negedge CLK);
         bus.in_valid = 1'b1;
         bus.in_data  = pl[i];
         bus.in_last  = use_last && (i == pl.size() - 1);
         @(posedge CLK);
      end
   endtask

   // Called right after the edge that accepted the closing byte.
   task automatic wait_frame(input int nbytes, input bit keep, input logic [7:0] hold, input string tag);
      int n;
      int errs;
      @(negedge CLK);
      if (keep) begin
         bus.in_data = hold;
         bus.in_last = 1'b1;
      end else begin
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
      end
      chk({tag, " busy rise"}, busy, 1);
      chk({tag, " ready drop"}, bus.in_ready, 0);
      chk({tag, " sync start bit"}, ct_UartTx, 0);
      n = 0;
      errs = 0;
      while (frame_done !== 1'b1 && n < 6000) begin
         if (bus.in_ready !== 1'b0 || busy !== 1'b1) errs++;
         @(negedge CLK);
         n++;
      end
      chk({tag, " frame_done latency"}, n, (2 + nbytes + C) * 10 * CPB);
      chk({tag, " ready/busy during frame"}, errs, 0);
      chk({tag, " busy low at done"}, busy, 0);
      chk({tag, " ready low at done"}, bus.in_ready, 0);
      chk({tag, " all bytes seen"}, exp_q.size(), 0);
      @(negedge CLK);
      chk({tag, " ready after done"}, bus.in_ready, 1);
      chk({tag, " done single pulse"}, frame_done, 0);
   endtask

   // Line decoder: mid-bit sampling on the falling clock edge.
   always begin
      logic [7:0] b;
      logic       st, sp;
      @(negedge ct_UartTx);
      repeat (CPB / 2) @(negedge CLK);
      st = ct_UartTx;
      for (int k = 0; k < 8; k++) begin
         repeat (CPB) @(negedge CLK);
         b[k] = ct_UartTx;
      end
      repeat (CPB) @(negedge CLK);
      sp = ct_UartTx;
      if (mon_en) begin
         chk("start bit", st, 0);
         chk("stop bit", sp, 1);
         chk("byte expected", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) chk("line byte", b, exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] pl [$];
      int errs;

      reset        = 1'b1;
      mon_en       = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset tx", ct_UartTx, 1);
      chk("reset ready", bus.in_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset done", frame_done, 0);
      reset = 1'b0;

      errs = 0;
      repeat (100) begin
         @(negedge CLK);
         if (ct_UartTx !== 1'b1 || bus.in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) errs++;
      end
      chk("idle 100 cycles", errs, 0);

      // A8,00,00 with in_last
      pl.delete();
      pl.push_back(8'hA8); pl.push_back(8'h00); pl.push_back(8'h00);
      push_frame(pl);
      send(pl, 1'b1);
      wait_frame(3, 1'b0, 8'h00, "A8 frame");

      // Buffer full: 01..08 with no in_last
      pl.delete();
      for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
      push_frame(pl);
      send(pl, 1'b0);
      wait_frame(8, 1'b0, 8'h00, "full frame");

      // Back-pressure: in_valid stays high through the frame with 0x33/last
      pl.delete();
      pl.push_back(8'h22);
      push_frame(pl);
      send(pl, 1'b1);
      wait_frame(1, 1'b1, 8'h33, "bp frame");
      pl.delete();
      pl.push_back(8'h33);
      push_frame(pl);
      @(posedge CLK);
      wait_frame(1, 1'b0, 8'h00, "bp next frame");

      // Reset in the middle of payload byte index 1
      mon_en = 1'b0;
      pl.delete();
      pl.push_back(8'h10); pl.push_back(8'h20); pl.push_back(8'h30);
      send(pl, 1'b1);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (560) @(negedge CLK);
      chk("pre-reset busy", busy, 1);
      reset = 1'b1;
      @(negedge CLK);
      chk("mid reset tx", ct_UartTx, 1);
      chk("mid reset busy", busy, 0);
      chk("mid reset ready", bus.in_ready, 1);
      chk("mid reset done", frame_done, 0);
      reset = 1'b0;
      errs = 0;
      repeat (300) begin
         @(negedge CLK);
         if (frame_done !== 1'b0 || ct_UartTx !== 1'b1) errs++;
      end
      chk("post reset quiet", errs, 0);
      mon_en = 1'b1;

      pl.delete();
      pl.push_back(8'h55);
      push_frame(pl);
      send(pl, 1'b1);
      wait_frame(1, 1'b0, 8'h00, "55 frame");

      chk("scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
